// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
//   Arbiter and access controller for a single-port synchronous instruction
//   memory shared by the core fetch port (read-only) and the program loader
//   (read/write). It grants at most one request per cycle and flags
//   misaligned or out-of-range addresses instead of issuing an access. It
//   routes each read return to its owner one cycle after the grant, and runs
//   a loader lock session (RUN -> LOAD -> RELEASE) that stalls the core.
//
// Build option:
//   IMEM_CTRL_STARVE_GUARD_EN - when defined, a wait counter forces a fetch
//   grant after MAX_WAIT consecutive denied fetch cycles in RUN. When
//   undefined, RUN arbitration is pure loader priority.
//
// Parameters:
//   N         memory depth in 32-bit words
//   MAX_WAIT  denied fetch cycles before the guard forces a fetch (1..15)
//
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   i_f_req, i_f_addr              fetch read request / byte address
//   o_f_gnt                        fetch accepted this cycle (combinational)
//   o_f_rvalid, o_f_rdata          fetch read return
//   i_l_req, i_l_we, i_l_addr,
//   i_l_wdata, i_l_lock            loader request, write flag, address, data,
//                                  session lock
//   o_l_gnt                        loader accepted this cycle (combinational)
//   o_l_rvalid, o_l_rdata          loader read return
//   o_err                          pulse: last accepted request was illegal
//   o_core_hold                    core fetch stall (LOAD and RELEASE)
//   o_mem_en, o_mem_we,
//   o_mem_addr, o_mem_wdata        memory command
//   i_mem_rdata                    memory read data (one cycle after read)
// -----------------------------------------------------------------------------
module imem_ctrl #(
  parameter int N        = 2048,
  parameter int MAX_WAIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_f_req,
  input  logic [31:0]          i_f_addr,
  output logic                 o_f_gnt,
  output logic                 o_f_rvalid,
  output logic [31:0]          o_f_rdata,
  input  logic                 i_l_req,
  input  logic                 i_l_we,
  input  logic [31:0]          i_l_addr,
  input  logic [31:0]          i_l_wdata,
  input  logic                 i_l_lock,
  output logic                 o_l_gnt,
  output logic                 o_l_rvalid,
  output logic [31:0]          o_l_rdata,
  output logic                 o_err,
  output logic                 o_core_hold,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [$clog2(N)-1:0] o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  input  logic [31:0]          i_mem_rdata
);

  localparam int          AW         = $clog2(N);
  localparam logic [31:0] ADDR_LIMIT = 32'(N * 4);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("imem_ctrl: MAX_WAIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;

  logic f_gnt_p0;
  logic l_gnt_p0;
  logic starve_p0;
  logic f_legal_p0;
  logic l_legal_p0;
  logic acc_legal_p0;
  logic any_gnt_p0;

  logic rd_vld_p1;
  logic rd_owner_p1;   // 1: return belongs to the loader
  logic err_p1;
  logic [31:0] f_rdata_q;
  logic [31:0] l_rdata_q;

`ifdef IMEM_CTRL_STARVE_GUARD_EN
  logic [3:0] wait_cnt;
  assign starve_p0 = (state == RUN) && (wait_cnt == 4'(MAX_WAIT));
`else
  assign starve_p0 = 1'b0;
`endif

  // ---- stage p0: arbitration and memory command (grant cycle) ----
  always_comb begin
    f_gnt_p0 = 1'b0;
    l_gnt_p0 = 1'b0;
    case (state)
      RUN: begin
        l_gnt_p0 = i_l_req & ~starve_p0;
        f_gnt_p0 = i_f_req & (~i_l_req | starve_p0);
      end
      LOAD: begin
        l_gnt_p0 = i_l_req;
      end
      default: begin
        // RELEASE issues no grants so an outstanding loader read can drain.
      end
    endcase
  end

  assign f_legal_p0   = (i_f_addr[1:0] == 2'b00) && (i_f_addr < ADDR_LIMIT);
  assign l_legal_p0   = (i_l_addr[1:0] == 2'b00) && (i_l_addr < ADDR_LIMIT);
  assign acc_legal_p0 = l_gnt_p0 ? l_legal_p0 : f_legal_p0;
  assign any_gnt_p0   = f_gnt_p0 | l_gnt_p0;

  assign o_f_gnt     = f_gnt_p0;
  assign o_l_gnt     = l_gnt_p0;
  assign o_mem_en    = any_gnt_p0 & acc_legal_p0;
  assign o_mem_we    = o_mem_en & l_gnt_p0 & i_l_we;
  assign o_mem_addr  = l_gnt_p0 ? i_l_addr[AW+1:2] : i_f_addr[AW+1:2];
  assign o_mem_wdata = i_l_wdata;

  // ---- stage p1: state, return tracking and error pulse ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= RUN;
      o_core_hold <= 1'b0;
      rd_vld_p1   <= 1'b0;
      rd_owner_p1 <= 1'b0;
      err_p1      <= 1'b0;
      f_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (i_l_lock) begin
            state       <= LOAD;
            o_core_hold <= 1'b1;
          end
        end
        LOAD: begin
          if (!i_l_lock) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state       <= RUN;
          o_core_hold <= 1'b0;
        end
        default: begin
          state       <= RUN;
          o_core_hold <= 1'b0;
        end
      endcase

      rd_vld_p1   <= o_mem_en & ~o_mem_we;
      rd_owner_p1 <= l_gnt_p0;
      err_p1      <= any_gnt_p0 & ~acc_legal_p0;

      // Remember the last returned word so the idle side keeps its value.
      if (o_f_rvalid) f_rdata_q <= i_mem_rdata;
      if (o_l_rvalid) l_rdata_q <= i_mem_rdata;
    end
  end

`ifdef IMEM_CTRL_STARVE_GUARD_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= '0;
    end else if ((state != RUN) || !i_f_req || f_gnt_p0) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 4'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`endif

  assign o_f_rvalid = rd_vld_p1 & ~rd_owner_p1;
  assign o_l_rvalid = rd_vld_p1 & rd_owner_p1;
  assign o_f_rdata  = o_f_rvalid ? i_mem_rdata : f_rdata_q;
  assign o_l_rdata  = o_l_rvalid ? i_mem_rdata : l_rdata_q;
  assign o_err      = err_p1;

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

  localparam int N        = 2048;
  localparam int MAX_WAIT = 4;
  localparam int AW       = 11;
`ifdef IMEM_CTRL_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          i_clk;
  logic          i_reset;
  logic          i_f_req;
  logic [31:0]   i_f_addr;
  logic          o_f_gnt;
  logic          o_f_rvalid;
  logic [31:0]   o_f_rdata;
  logic          i_l_req;
  logic          i_l_we;
  logic [31:0]   i_l_addr;
  logic [31:0]   i_l_wdata;
  logic          i_l_lock;
  logic          o_l_gnt;
  logic          o_l_rvalid;
  logic [31:0]   o_l_rdata;
  logic          o_err;
  logic          o_core_hold;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  imem_ctrl #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_gnt(o_f_gnt),
    .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr),
    .i_l_wdata(i_l_wdata), .i_l_lock(i_l_lock), .o_l_gnt(o_l_gnt),
    .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata),
    .o_err(o_err), .o_core_hold(o_core_hold),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous single-port memory the controller drives.
  logic [31:0] mem [N];
  logic [31:0] mem_q;
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          mem_q <= mem[o_mem_addr];
    end
  end
  assign i_mem_rdata = mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: expected contents, session phase, pending return.
  logic [31:0] ref_mem [N];
  int          m_phase;       // 0 running, 1 loader session, 2 draining
  int          m_wait;
  bit          pend_vld;
  bit          pend_ldr;
  logic [31:0] pend_data;
  bit          m_err;
  logic [31:0] m_f_rdata;
  logic [31:0] m_l_rdata;

  always @(negedge i_clk) begin
    bit          eg_f, eg_l, starve, legal, en, wr, fret, lret;
    logic [31:0] addr;
    int          widx;
    if (i_reset) begin
      m_phase = 0; m_wait = 0; pend_vld = 0; pend_ldr = 0; m_err = 0;
      m_f_rdata = '0; m_l_rdata = '0;
      chk("rst_core_hold", 32'(o_core_hold), 32'd0);
      chk("rst_f_rvalid", 32'(o_f_rvalid), 32'd0);
      chk("rst_l_rvalid", 32'(o_l_rvalid), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_f_rdata", o_f_rdata, 32'd0);
      chk("rst_l_rdata", o_l_rdata, 32'd0);
    end else begin
      starve = GUARD && (m_phase == 0) && (m_wait == MAX_WAIT);
      eg_f = 0; eg_l = 0;
      if (m_phase == 0) begin
        if (starve)       eg_f = i_f_req;
        else if (i_l_req) eg_l = 1;
        else              eg_f = i_f_req;
      end else if (m_phase == 1) begin
        eg_l = i_l_req;
      end
      addr  = eg_l ? i_l_addr : i_f_addr;
      legal = (addr % 4 == 0) && (addr < 32'(N * 4));
      en    = (eg_f || eg_l) && legal;
      wr    = en && eg_l && i_l_we;
      widx  = int'(addr / 4) % N;
      fret  = pend_vld && !pend_ldr;
      lret  = pend_vld && pend_ldr;
      if (fret) m_f_rdata = pend_data;
      if (lret) m_l_rdata = pend_data;

      chk("f_gnt", 32'(o_f_gnt), 32'(eg_f));
      chk("l_gnt", 32'(o_l_gnt), 32'(eg_l));
      chk("mem_en", 32'(o_mem_en), 32'(en));
      if (en) begin
        chk("mem_addr", 32'(o_mem_addr), 32'(widx));
        chk("mem_we", 32'(o_mem_we), 32'(wr));
        if (wr) chk("mem_wdata", o_mem_wdata, i_l_wdata);
      end
      chk("f_rvalid", 32'(o_f_rvalid), 32'(fret));
      chk("l_rvalid", 32'(o_l_rvalid), 32'(lret));
      chk("f_rdata", o_f_rdata, m_f_rdata);
      chk("l_rdata", o_l_rdata, m_l_rdata);
      chk("err", 32'(o_err), 32'(m_err));
      chk("core_hold", 32'(o_core_hold), 32'(m_phase != 0));

      if (wr) ref_mem[widx] = i_l_wdata;
      pend_vld  = en && !wr;
      pend_ldr  = eg_l;
      pend_data = ref_mem[widx];
      m_err     = (eg_f || eg_l) && !legal;
      if (m_phase == 0 && i_f_req && !eg_f)
        m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else
        m_wait = 0;
      case (m_phase)
        0:       if (i_l_lock)  m_phase = 1;
        1:       if (!i_l_lock) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic nc();
    @(posedge i_clk);
    #1;
  endtask

  int fg_cnt, fg_first;
  bit hold_s [11];
  bit fg_s   [11];
  bit frv_s  [11];
  int fg_locked;

  initial begin
    i_reset = 1'b1; i_f_req = 0; i_f_addr = '0; i_l_req = 0; i_l_we = 0;
    i_l_addr = '0; i_l_wdata = '0; i_l_lock = 0;
    for (int i = 0; i < N; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[0] = 32'h0000_0013; ref_mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093; ref_mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113; ref_mem[2] = 32'h0020_0113;
    mem_q = '0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Fetch-only stream
    i_f_req = 1; i_f_addr = 32'h0;
    @(negedge i_clk) chk("fetch_gnt0", 32'(o_f_gnt), 32'd1);
    nc(); i_f_addr = 32'h4;
    @(negedge i_clk) chk("fetch_rdata0", o_f_rdata, 32'h0000_0013);
    nc(); i_f_addr = 32'h8;
    @(negedge i_clk) chk("fetch_rdata1", o_f_rdata, 32'h0010_0093);
    nc(); i_f_req = 0;
    @(negedge i_clk) begin
      chk("fetch_rvalid2", 32'(o_f_rvalid), 32'd1);
      chk("fetch_rdata2", o_f_rdata, 32'h0020_0113);
    end
    nc();

    // Loader write followed by fetch of the same word
    i_l_req = 1; i_l_we = 1; i_l_addr = 32'h10; i_l_wdata = 32'hDEAD_BEEF;
    @(negedge i_clk) chk("wr_mem_we", 32'(o_mem_we), 32'd1);
    nc(); i_l_req = 0; i_l_we = 0; i_f_req = 1; i_f_addr = 32'h10;
    nc(); i_f_req = 0;
    @(negedge i_clk) chk("wr_then_fetch", o_f_rdata, 32'hDEAD_BEEF);
    nc();

    // Continuous contention
    i_f_req = 1; i_f_addr = 32'h24; i_l_req = 1; i_l_we = 0; i_l_addr = 32'h20;
    fg_cnt = 0; fg_first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk) if (o_f_gnt) begin
        fg_cnt++;
        if (fg_first == 0) fg_first = c;
      end
      nc();
    end
    i_f_req = 0; i_l_req = 0;
    chk("starve_fetch_grants", 32'(fg_cnt), GUARD ? 32'd4 : 32'd0);
    chk("starve_first_grant", 32'(fg_first), GUARD ? 32'd5 : 32'd0);
    nc();

    // Loader lock session with fetch held high
    i_f_req = 1; i_f_addr = 32'h8; i_l_lock = 1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 7) i_l_lock = 0;
      if (c == 3) begin i_l_req = 1; i_l_we = 1; i_l_addr = 32'h40; i_l_wdata = 32'h1234_5678; end
      if (c == 4) begin i_l_req = 0; i_l_we = 0; end
      @(negedge i_clk) begin
        hold_s[c] = o_core_hold; fg_s[c] = o_f_gnt; frv_s[c] = o_f_rvalid;
      end
      nc();
    end
    i_f_req = 0;
    fg_locked = 0;
    for (int c = 2; c <= 8; c++) fg_locked += int'(fg_s[c]);
    chk("lock_hold_c1", 32'(hold_s[1]), 32'd0);
    chk("lock_hold_c2", 32'(hold_s[2]), 32'd1);
    chk("lock_hold_c8", 32'(hold_s[8]), 32'd1);
    chk("lock_hold_c9", 32'(hold_s[9]), 32'd0);
    chk("lock_fgnt_c1", 32'(fg_s[1]), 32'd1);
    chk("lock_fgnt_locked", 32'(fg_locked), 32'd0);
    chk("lock_fgnt_c9", 32'(fg_s[9]), 32'd1);
    chk("lock_frvalid_c2", 32'(frv_s[2]), 32'd1);
    nc();

    // Illegal addresses and last legal word
    i_f_req = 1; i_f_addr = 32'h6;
    @(negedge i_clk) chk("misalign_mem_en", 32'(o_mem_en), 32'd0);
    nc(); i_f_req = 0;
    @(negedge i_clk) begin
      chk("misalign_err", 32'(o_err), 32'd1);
      chk("misalign_rvalid", 32'(o_f_rvalid), 32'd0);
    end
    nc();
    i_l_req = 1; i_l_we = 0; i_l_addr = 32'h2000;
    @(negedge i_clk) begin
      chk("range_l_gnt", 32'(o_l_gnt), 32'd1);
      chk("range_mem_en", 32'(o_mem_en), 32'd0);
    end
    nc(); i_l_addr = 32'h1FFC;
    @(negedge i_clk) begin
      chk("range_err", 32'(o_err), 32'd1);
      chk("range_rvalid", 32'(o_l_rvalid), 32'd0);
      chk("last_word_addr", 32'(o_mem_addr), 32'd2047);
    end
    nc(); i_l_req = 0;
    @(negedge i_clk) chk("last_word_rdata", o_l_rdata, 32'h1000_07FF);
    nc();

    // Reset right after a loader read grant
    i_l_req = 1; i_l_we = 0; i_l_addr = 32'h10;
    nc(); i_l_req = 0; i_reset = 1;
    @(negedge i_clk) chk("rst_drop_rvalid", 32'(o_l_rvalid), 32'd0);
    nc(); i_reset = 0;
    @(negedge i_clk) chk("rst_after_rvalid", 32'(o_l_rvalid), 32'd0);
    nc();

    // Reset in the middle of a loader session
    i_l_lock = 1;
    nc();
    @(negedge i_clk) chk("session_hold", 32'(o_core_hold), 32'd1);
    nc(); i_l_lock = 0; i_reset = 1;
    @(negedge i_clk) chk("session_rst_hold", 32'(o_core_hold), 32'd0);
    nc(); i_reset = 0; i_f_req = 1; i_f_addr = 32'h40;
    @(negedge i_clk) chk("session_rst_fgnt", 32'(o_f_gnt), 32'd1);
    nc(); i_f_req = 0;
    @(negedge i_clk) chk("lock_write_data", o_f_rdata, 32'h1234_5678);
    nc(); nc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Shares the single-port synchronous instruction memory between the core fetch port (read-only) and the program-loader port (read/write). It handles per-request arbitration, a loader lock session and one-cycle read-return tracking. It sits between the fetch stage / loader and the memory array, and it flags misaligned or out-of-range addresses without issuing an access.

## Interface
- N, 2048: memory depth in 32-bit words; a byte address is legal when it is below N*4.
- MAX_WAIT, 4: consecutive denied fetch cycles before the starvation guard forces a fetch grant (1..15).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_f_req  in  1  fetch read request.
- i_f_addr  in  32  fetch byte address.
- o_f_gnt  out  1  fetch request accepted this cycle (combinational).
- o_f_rvalid  out  1  fetch read data valid.
- o_f_rdata  out  32  fetch read data.
- i_l_req  in  1  loader request.
- i_l_we  in  1  loader write (1) / read (0).
- i_l_addr  in  32  loader byte address.
- i_l_wdata  in  32  loader write data.
- i_l_lock  in  1  loader session lock.
- o_l_gnt  out  1  loader request accepted (combinational).
- o_l_rvalid  out  1  loader read data valid.
- o_l_rdata  out  32  loader read data.
- o_err  out  1  one-cycle pulse: accepted request was misaligned or out of range.
- o_core_hold  out  1  high in LOAD and RELEASE; tells the core to stall fetch.
- o_mem_en, o_mem_we  out  1  memory enable / write enable.
- o_mem_addr  out  $clog2(N)  word address, taken from addr[$clog2(N)+1:2].
- o_mem_wdata  out  32  write data.
- i_mem_rdata  in  32  memory read data, valid one cycle after o_mem_en with o_mem_we=0.

## Operation
- FSM states: RUN, LOAD, RELEASE. Reset state is RUN.
- RUN -> LOAD when i_l_lock=1. LOAD -> RELEASE when i_l_lock=0. RELEASE -> RUN unconditionally after 1 cycle.
- RUN arbitration: the loader has priority. o_l_gnt = i_l_req. o_f_gnt = i_f_req & ~i_l_req, except when the starvation guard fires.
- Starvation guard: wait_cnt counts cycles with i_f_req=1 and o_f_gnt=0. It is cleared on any fetch grant or when i_f_req=0, and saturates at MAX_WAIT.
  - When wait_cnt==MAX_WAIT, fetch wins that cycle and the loader is denied.
- LOAD: only the loader is granted; o_f_gnt=0; wait_cnt is held at 0.
- RELEASE: no grants are issued. This lets an outstanding loader read return.
- Granted request with addr[1:0]!=0 or addr>=N*4:
  - o_err pulses in the next cycle.
  - o_mem_en stays 0 and no rvalid is produced for that request.
- Legal granted request: drives o_mem_en=1, o_mem_addr, o_mem_we=i_l_we (fetch: 0), o_mem_wdata in the grant cycle. The write commits at that edge.
- Read return routing:
  - A 1-bit registered owner tag steers i_mem_rdata to o_f_rdata or o_l_rdata in the next cycle.
  - The other rdata output holds its last value.
- Back-to-back grants every cycle are supported with no bubbles.
- Reset values: every output register 0; state RUN; wait_cnt 0; owner tag 0; rvalids 0; o_err 0. o_core_hold is 0 after reset.
- Reset asserted mid-operation clears everything immediately. An in-flight read return is dropped and no rvalid is produced.

## Timing
- Grant to rvalid latency: exactly 1 cycle (grant in cycle t, rvalid and rdata in t+1).
- Write: the memory updates at the end of the grant cycle. A read of the same address granted in t+1 returns the new data in t+2.
- o_core_hold: rises in the cycle after i_l_lock is first sampled high. It falls in the cycle after RELEASE.
- i_l_lock rising while a fetch read is outstanding: the fetch rvalid is still delivered in the next cycle.
- Requesters hold req/addr/data stable until they are granted.

## Configuration
- IMEM_CTRL_STARVE_GUARD_EN defined: the starvation guard and wait_cnt are present as described above.
- Not defined: wait_cnt is removed and arbitration in RUN is pure loader priority; o_f_gnt = i_f_req & ~i_l_req.

## Test plan
- Fetch only: req at 0x0, 0x4, 0x8 in consecutive cycles with memory preloaded with 0x00000013, 0x00100093, 0x00200113 -> three grants, then rvalid on three consecutive cycles with data in order.
- Loader write 0xDEADBEEF to 0x10, then fetch 0x10 in the next cycle -> o_f_rdata=0xDEADBEEF two cycles after the write grant.
- Both requesting continuously with MAX_WAIT=4 and the guard compiled in -> fetch granted on every 5th cycle. With the guard compiled out -> fetch is never granted.
- i_l_lock high for 6 cycles with i_f_req held high:
  - o_core_hold=1 from cycle 2;
  - zero fetch grants during LOAD and RELEASE;
  - the first fetch grant arrives in the cycle after RELEASE.
- Fetch at 0x6 and loader at 0x2000 (N=2048) -> o_err pulses for each request, o_mem_en=0, no rvalid.
- Reset asserted in the cycle after a loader read grant -> o_l_rvalid stays 0 and the state returns to RUN.
